multi7: RTL and testbench

//   Time-multiplexed driver for a bank of DIGITS common-segment 7-segment displays.

---
 rtl/seg7_pkg.sv | 22 ++
 rtl/hex7_decode.sv | 14 +
 rtl/multi7.sv | 63 ++++++
 tb/tb_multi7.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared seven-segment definitions: segment bit positions and the hex glyph table.
// Patterns are active-high with bit0=a ... bit6=g.
package seg7_pkg;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;

    localparam int unsigned NIBBLE_W = 4;
    localparam int unsigned SEG_W    = 7;

    // Indexed by nibble value; lower-case b and d keep 6/8 and B/D distinguishable.
    localparam logic [SEG_W-1:0] HEX7_TABLE [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex7_decode.sv
// Combinational hex nibble to seven-segment pattern lookup.
module hex7_decode
    import seg7_pkg::*;
(
    input  logic [NIBBLE_W-1:0] nibble,
    output logic [SEG_W-1:0]    pattern
);

    // Table lookup covers all 16 nibble values, so no fallback is needed.
    always_comb begin
        pattern = HEX7_TABLE[nibble];
    end

endmodule

// File: rtl/multi7.sv
// Time-multiplexed driver for a bank of common-segment 7-segment displays.
// Each display is enabled for CYCLES_PER_DIGIT clocks in turn; outputs are registered.
module multi7
    import seg7_pkg::*;
#(
    parameter int DIGITS           = 4,
    parameter int CYCLES_PER_DIGIT = 16
) (
    input  logic                         i_clk,
    input  logic                         i_rst,
    input  logic [DIGITS*NIBBLE_W-1:0]   i_digits,
    output logic [SEG_W-1:0]             o_segments_drive,
    output logic [DIGITS-1:0]            o_displays_neg
);

    localparam int CNT_W = (CYCLES_PER_DIGIT > 1) ? $clog2(CYCLES_PER_DIGIT) : 1;
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CYCLES_PER_DIGIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    logic [CNT_W-1:0]           cnt_r;
    logic [IDX_W-1:0]           idx_r;
    logic [DIGITS*NIBBLE_W-1:0] shifted_s;
    logic [NIBBLE_W-1:0]        nibble_s;
    logic [SEG_W-1:0]           pattern_s;
    logic [DIGITS-1:0]          enable_s;

    // Select the active nibble and build the one-cold enable from the current index.
    always_comb begin
        shifted_s = i_digits >> {idx_r, 2'b00};
        nibble_s  = shifted_s[NIBBLE_W-1:0];
        enable_s  = ~(DIGITS'(1'b1) << idx_r);
    end

    hex7_decode u_decode (
        .nibble  (nibble_s),
        .pattern (pattern_s)
    );

    // Prescaler, scan index and output registers; outputs lag the index by one clock.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_r            <= {CNT_W{1'b0}};
            idx_r            <= {IDX_W{1'b0}};
            o_displays_neg   <= {DIGITS{1'b1}};
            o_segments_drive <= {SEG_W{1'b0}};
        end else begin
            o_displays_neg   <= enable_s;
            o_segments_drive <= pattern_s;
            if (cnt_r == CNT_LAST) begin
                cnt_r <= {CNT_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_r <= {IDX_W{1'b0}};
                end else begin
                    idx_r <= idx_r + IDX_W'(1'b1);
                end
            end else begin
                cnt_r <= cnt_r + CNT_W'(1'b1);
            end
        end
    end

endmodule

// File: tb/tb_multi7.sv
// Self-checking bench for multi7: default configuration plus DIGITS=1 and CYCLES_PER_DIGIT=1 corners.
module tb_multi7;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [15:0] dig_a, dig_c;
    logic [3:0]  dig_b;
    logic [6:0]  seg_a, seg_b, seg_c;
    logic [3:0]  neg_a, neg_c;
    logic [0:0]  neg_b;

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [6:0] hex_tbl [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    multi7 #(.DIGITS(4), .CYCLES_PER_DIGIT(16)) u_a (
        .i_clk(clk), .i_rst(rst), .i_digits(dig_a),
        .o_segments_drive(seg_a), .o_displays_neg(neg_a));
    multi7 #(.DIGITS(1), .CYCLES_PER_DIGIT(16)) u_b (
        .i_clk(clk), .i_rst(rst), .i_digits(dig_b),
        .o_segments_drive(seg_b), .o_displays_neg(neg_b));
    multi7 #(.DIGITS(4), .CYCLES_PER_DIGIT(1)) u_c (
        .i_clk(clk), .i_rst(rst), .i_digits(dig_c),
        .o_segments_drive(seg_c), .o_displays_neg(neg_c));

    // Reference model: n_r counts edges since reset was last seen; inputs captured at each edge.
    int          n_r = 0;
    logic        rst_q = 1'b1;
    logic [15:0] dig_a_q, dig_c_q;
    always @(posedge clk) begin
        rst_q   <= rst;
        n_r     <= rst ? 0 : n_r + 1;
        dig_a_q <= dig_a;
        dig_c_q <= dig_c;
    end

    // After edge n (n>=1) the display shown is ((n-1)/cpd) mod d.
    function automatic logic [3:0] exp_neg(int d, int cpd);
        logic [3:0] mask;
        mask = 4'hF >> (4 - d);
        if (rst_q || n_r == 0) return mask;
        return mask & ~(4'b0001 << (((n_r - 1) / cpd) % d));
    endfunction

    function automatic logic [6:0] exp_seg(int d, int cpd, logic [15:0] dig);
        logic [15:0] t;
        if (rst_q || n_r == 0) return 7'h00;
        t = dig >> (4 * (((n_r - 1) / cpd) % d));
        return hex_tbl[t[3:0]];
    endfunction

    task automatic test_reset();
        rst   = 1'b1;
        dig_a = 16'(($urandom));
        dig_b = 4'($urandom);
        dig_c = 16'($urandom);
        repeat (3) begin
            @(negedge clk);
            total_cnt++; if (neg_a !== 4'hF) $display("FAIL reset neg_a: got %b want 1111", neg_a); else pass_cnt++;
            total_cnt++; if (seg_a !== 7'h00) $display("FAIL reset seg_a: got %h want 00", seg_a); else pass_cnt++;
            total_cnt++; if (neg_b !== 1'b1) $display("FAIL reset neg_b: got %b want 1", neg_b); else pass_cnt++;
            total_cnt++; if (seg_b !== 7'h00) $display("FAIL reset seg_b: got %h want 00", seg_b); else pass_cnt++;
            total_cnt++; if (neg_c !== 4'hF) $display("FAIL reset neg_c: got %b want 1111", neg_c); else pass_cnt++;
        end
    endtask

    task automatic test_scan();
        logic [3:0] want_neg [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        logic [6:0] want_seg [4] = '{7'h66, 7'h4F, 7'h5B, 7'h06};
        logic [3:0] prev_a, prev_c;
        int run_a;
        rst   = 1'b0;
        dig_a = 16'h1234;
        dig_b = 4'hE;
        dig_c = 16'h9A5C;
        run_a = 0;
        prev_a = 4'hF;
        prev_c = 4'hF;
        for (int cyc = 0; cyc < 128; cyc++) begin
            @(negedge clk);
            total_cnt++; if (neg_a !== want_neg[(cyc / 16) % 4] || seg_a !== want_seg[(cyc / 16) % 4])
                $display("FAIL scan_a cyc %0d: got %b/%h want %b/%h", cyc, neg_a, seg_a,
                         want_neg[(cyc / 16) % 4], want_seg[(cyc / 16) % 4]);
            else pass_cnt++;
            total_cnt++; if ($countones(~neg_a) != 1) $display("FAIL onehot_a cyc %0d: got %b want one low bit", cyc, neg_a); else pass_cnt++;
            if (cyc > 0 && neg_a !== prev_a) begin
                total_cnt++; if (run_a != 16) $display("FAIL window_a cyc %0d: got %0d want 16", cyc, run_a); else pass_cnt++;
                run_a = 1;
            end else begin
                run_a++;
            end
            prev_a = neg_a;
            total_cnt++; if (neg_b !== 1'b0 || seg_b !== 7'h79) $display("FAIL digits1 cyc %0d: got %b/%h want 0/79", cyc, neg_b, seg_b); else pass_cnt++;
            total_cnt++; if (neg_c !== exp_neg(4, 1) || seg_c !== exp_seg(4, 1, dig_c_q))
                $display("FAIL cpd1 cyc %0d: got %b/%h want %b/%h", cyc, neg_c, seg_c, exp_neg(4, 1), exp_seg(4, 1, dig_c_q));
            else pass_cnt++;
            if (cyc > 0) begin
                total_cnt++; if (neg_c === prev_c) $display("FAIL rotate_c cyc %0d: got %b again want change", cyc, neg_c); else pass_cnt++;
            end
            prev_c = neg_c;
        end
    endtask

    task automatic test_reset_mid();
        bit found;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            if (neg_a === 4'b1011) found = 1'b1;
        end
        total_cnt++; if (!found) $display("FAIL midreset_wait: got no display 2 want display 2 within 200 cycles"); else pass_cnt++;
        rst = 1'b1;
        @(negedge clk);
        total_cnt++; if (neg_a !== 4'hF || seg_a !== 7'h00) $display("FAIL midreset_off: got %b/%h want 1111/00", neg_a, seg_a); else pass_cnt++;
        total_cnt++; if (neg_c !== 4'hF || neg_b !== 1'b1) $display("FAIL midreset_off_bc: got %b/%b want 1111/1", neg_c, neg_b); else pass_cnt++;
        rst = 1'b0;
        @(negedge clk);
        total_cnt++; if (neg_a !== 4'b1110 || seg_a !== hex_tbl[dig_a[3:0]])
            $display("FAIL midreset_restart: got %b/%h want 1110/%h", neg_a, seg_a, hex_tbl[dig_a[3:0]]);
        else pass_cnt++;
    endtask

    task automatic test_sweep();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        dig_a = 16'h5A70;
        for (int v = 0; v < 16; v++) begin
            dig_a[3:0] = 4'(v);
            @(negedge clk);
            total_cnt++; if (seg_a !== hex_tbl[v] || neg_a !== 4'b1110)
                $display("FAIL sweep nibble %0h: got %b/%h want 1110/%h", v, neg_a, seg_a, hex_tbl[v]);
            else pass_cnt++;
        end
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 400; cyc++) begin
            rst = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 3) == 0) dig_a = 16'($urandom);
            if ($urandom_range(0, 3) == 0) dig_b = 4'($urandom);
            if ($urandom_range(0, 3) == 0) dig_c = 16'($urandom);
            @(negedge clk);
            total_cnt++; if (neg_a !== exp_neg(4, 16) || seg_a !== exp_seg(4, 16, dig_a_q))
                $display("FAIL random_a cyc %0d: got %b/%h want %b/%h", cyc, neg_a, seg_a, exp_neg(4, 16), exp_seg(4, 16, dig_a_q));
            else pass_cnt++;
            total_cnt++; if (neg_c !== exp_neg(4, 1) || seg_c !== exp_seg(4, 1, dig_c_q))
                $display("FAIL random_c cyc %0d: got %b/%h want %b/%h", cyc, neg_c, seg_c, exp_neg(4, 1), exp_seg(4, 1, dig_c_q));
            else pass_cnt++;
            total_cnt++; if ({3'b000, neg_b} !== exp_neg(1, 16))
                $display("FAIL random_b cyc %0d: got %b want %b", cyc, neg_b, exp_neg(1, 16));
            else pass_cnt++;
            if (!rst_q) begin
                total_cnt++; if ($countones(~neg_a) != 1 || $countones(~neg_c) != 1)
                    $display("FAIL random_onehot cyc %0d: got %b/%b want one low bit each", cyc, neg_a, neg_c);
                else pass_cnt++;
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        dig_a = 16'h0000;
        dig_b = 4'h0;
        dig_c = 16'h0000;
        test_reset();
        test_scan();
        test_reset_mid();
        test_sweep();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
